// File: rtl/j_fdsync6_ldarb.sv
// Round-robin load arbiter/sequencer for the shared 6-bit j_fdsync6 holding register.
// Each grant runs IDLE -> LOAD -> ACK [-> HOLD] and drives one ld pulse followed by one ack pulse.
module j_fdsync6_ldarb #(
    parameter  int NREQ = 4,
    parameter  int HOLD = 1,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [6*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              ld,
    output logic [5:0]        d,
    output logic [GW-1:0]     gid,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACK,
        ST_HOLD
    } state_t;

    localparam logic [3:0]    HOLD_INIT = 4'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [GW-1:0] PTR_INIT  = GW'(NREQ - 1);

    state_t        state, state_nx;
    logic [GW-1:0] ptr, ptr_nx;
    logic [GW-1:0] gid_nx;
    logic [3:0]    cnt, cnt_nx;

    logic          any_req;
    logic [GW-1:0] winner;
    logic [GW-1:0] idx;
    logic [5:0]    slice [NREQ];

    // Visit offsets from farthest to nearest so the nearest asserted request after ptr is the last write.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = GW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gid_nx   = gid;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nx = ST_LOAD;
                    ptr_nx   = winner;
                    gid_nx   = winner;
                end
            end
            ST_LOAD: state_nx = ST_ACK;
            ST_ACK: begin
                if (HOLD > 0) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = HOLD_INIT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt == 4'd0) state_nx = ST_IDLE;
                else             cnt_nx   = cnt - 4'd1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= PTR_INIT;
            gid   <= '0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            gid   <= gid_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) slice[i] = data[6*i +: 6];
    end

    // Outputs decode registered state only; reset gates ld so the register never loads in a reset cycle.
    always_comb begin
        ack = '0;
        if (state == ST_ACK) ack[gid] = 1'b1;
    end

    assign ld   = (state == ST_LOAD) && !reset;
    assign busy = (state != ST_IDLE);
    assign d    = slice[gid];

endmodule

// File: tb/tb_j_fdsync6_ldarb.sv
// Directed bench for j_fdsync6_ldarb: three instances (HOLD=1, 0, 3) plus a model of the shared register.
// Expected loads are queued at stimulus time and popped when ld is observed.
module tb_j_fdsync6_ldarb;

    typedef struct packed {
        logic [1:0] gid;
        logic [5:0] d;
    } exp_t;

    logic sys_clk;
    logic reset;

    logic [3:0]  req1, req0, req3;
    logic [23:0] data1, data0, data3;
    logic [3:0]  ack1, ack0, ack3;
    logic        ld1, ld0, ld3;
    logic [5:0]  d1, d0, d3;
    logic [1:0]  gid1, gid0, gid3;
    logic        busy1, busy0, busy3;
    logic [5:0]  q1;

    exp_t sb1[$], sb0[$], sb3[$];
    exp_t e1, e0, e3;

    int n_cmp = 0;
    int n_err = 0;

    j_fdsync6_ldarb #(.NREQ(4), .HOLD(1)) dut_h1 (
        .sys_clk(sys_clk), .reset(reset), .req(req1), .data(data1),
        .ack(ack1), .ld(ld1), .d(d1), .gid(gid1), .busy(busy1)
    );

    j_fdsync6_ldarb #(.NREQ(4), .HOLD(0)) dut_h0 (
        .sys_clk(sys_clk), .reset(reset), .req(req0), .data(data0),
        .ack(ack0), .ld(ld0), .d(d0), .gid(gid0), .busy(busy0)
    );

    j_fdsync6_ldarb #(.NREQ(4), .HOLD(3)) dut_h3 (
        .sys_clk(sys_clk), .reset(reset), .req(req3), .data(data3),
        .ack(ack3), .ld(ld3), .d(d3), .gid(gid3), .busy(busy3)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Model of the external j_fdsync6 register driven by the HOLD=1 instance.
    initial q1 = 6'h00;
    always @(posedge sys_clk) if (ld1) q1 <= d1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (ld1 === 1'b1) begin
            if (sb1.size() == 0) check("h1_ld_unexpected", 32'(ld1), 32'd0);
            else begin
                e1 = sb1.pop_front();
                check("h1_ld_gid", 32'(gid1), 32'(e1.gid));
                check("h1_ld_d", 32'(d1), 32'(e1.d));
            end
        end
    end

    always @(negedge sys_clk) begin
        if (ld0 === 1'b1) begin
            if (sb0.size() == 0) check("h0_ld_unexpected", 32'(ld0), 32'd0);
            else begin
                e0 = sb0.pop_front();
                check("h0_ld_gid", 32'(gid0), 32'(e0.gid));
                check("h0_ld_d", 32'(d0), 32'(e0.d));
            end
        end
    end

    always @(negedge sys_clk) begin
        if (ld3 === 1'b1) begin
            if (sb3.size() == 0) check("h3_ld_unexpected", 32'(ld3), 32'd0);
            else begin
                e3 = sb3.pop_front();
                check("h3_ld_gid", 32'(gid3), 32'(e3.gid));
                check("h3_ld_d", 32'(d3), 32'(e3.d));
            end
        end
    end

    initial begin
        logic [3:0] oh;
        logic [1:0] k;

        reset = 1'b1;
        req1 = 4'b0; req0 = 4'b0; req3 = 4'b0;
        data1 = 24'h000000;
        data0 = {6'h04, 6'h33, 6'h22, 6'h11};
        data3 = {6'h00, 6'h00, 6'h3C, 6'h01};
        data1[5:0] = 6'h19;
        tick();
        tick();

        // Reset values.
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_ld", 32'(ld1), 32'd0);
        check("rst_ack", 32'(ack1), 32'd0);
        check("rst_gid", 32'(gid1), 32'd0);
        check("rst_d", 32'(d1), 32'h19);
        reset = 1'b0;
        data1[5:0] = 6'h00;

        // Single request after reset, HOLD=1.
        data1[17:12] = 6'h2A;
        req1 = 4'b0100;
        sb1.push_back(exp_t'{2'd2, 6'h2A});
        tick();
        check("t1_ld", 32'(ld1), 32'd1);
        check("t1_d", 32'(d1), 32'h2A);
        check("t1_gid", 32'(gid1), 32'd2);
        check("t1_busy_load", 32'(busy1), 32'd1);
        tick();
        check("t1_ack", 32'(ack1), 32'b0100);
        check("t1_q", 32'(q1), 32'h2A);
        check("t1_ld_ack", 32'(ld1), 32'd0);
        check("t1_busy_ack", 32'(busy1), 32'd1);
        req1 = 4'b0000;
        tick();
        check("t1_busy_hold", 32'(busy1), 32'd1);
        check("t1_ack_hold", 32'(ack1), 32'd0);
        tick();
        check("t1_busy_idle", 32'(busy1), 32'd0);

        // Continuous requests on all four, HOLD=0: order 0,1,2,3,0, one grant every 3 cycles.
        for (int g = 0; g < 5; g++) begin
            k = 2'(g % 4);
            sb0.push_back(exp_t'{k, data0[6*k +: 6]});
        end
        req0 = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            k = 2'(g % 4);
            oh = 4'b0001 << k;
            tick();
            check("t2_ld", 32'(ld0), 32'd1);
            check("t2_gid", 32'(gid0), 32'(k));
            tick();
            check("t2_ack", 32'(ack0), 32'(oh));
            if (g == 4) req0 = 4'b0000;
            tick();
            check("t2_idle", 32'(busy0), 32'd0);
        end

        // Wrap-around fairness: serve 3, then 1001 together -> 0 before 3.
        req0 = 4'b1000;
        sb0.push_back(exp_t'{2'd3, 6'h04});
        tick();
        check("t3_first_gid", 32'(gid0), 32'd3);
        tick();
        check("t3_first_ack", 32'(ack0), 32'b1000);
        req0 = 4'b0000;
        tick();
        req0 = 4'b1001;
        sb0.push_back(exp_t'{2'd0, 6'h11});
        sb0.push_back(exp_t'{2'd3, 6'h04});
        tick();
        check("t3_wrap_gid", 32'(gid0), 32'd0);
        tick();
        check("t3_wrap_ack", 32'(ack0), 32'b0001);
        req0 = 4'b1000;
        tick();
        check("t3_idle", 32'(busy0), 32'd0);
        tick();
        check("t3_second_gid", 32'(gid0), 32'd3);
        tick();
        check("t3_second_ack", 32'(ack0), 32'b1000);
        req0 = 4'b0000;
        tick();

        // HOLD=3 back-to-back: three busy/no-ld cycles after ack, 6-cycle period.
        req3 = 4'b0011;
        sb3.push_back(exp_t'{2'd0, 6'h01});
        sb3.push_back(exp_t'{2'd1, 6'h3C});
        for (int g = 0; g < 2; g++) begin
            oh = 4'b0001 << g;
            tick();
            check("t4_ld", 32'(ld3), 32'd1);
            check("t4_gid", 32'(gid3), 32'(g));
            tick();
            check("t4_ack", 32'(ack3), 32'(oh));
            if (g == 1) req3 = 4'b0000;
            for (int h = 0; h < 3; h++) begin
                tick();
                check("t4_hold_busy", 32'(busy3), 32'd1);
                check("t4_hold_ld", 32'(ld3), 32'd0);
            end
            tick();
            check("t4_idle_busy", 32'(busy3), 32'd0);
            check("t4_idle_ld", 32'(ld3), 32'd0);
        end

        // Load 6'h00 so the register holds zero before the aborted load.
        req1 = 4'b0001;
        sb1.push_back(exp_t'{2'd0, 6'h00});
        tick();
        tick();
        req1 = 4'b0000;
        tick();
        tick();
        check("t5_q_pre", 32'(q1), 32'h00);

        // Reset during LOAD.
        data1[11:6] = 6'h15;
        req1 = 4'b0010;
        tick();
        check("t5_gid", 32'(gid1), 32'd1);
        check("t5_d", 32'(d1), 32'h15);
        reset = 1'b1;
        #1;
        check("t5_ld_gated", 32'(ld1), 32'd0);
        tick();
        check("t5_busy", 32'(busy1), 32'd0);
        check("t5_ack", 32'(ack1), 32'd0);
        check("t5_q_kept", 32'(q1), 32'h00);
        reset = 1'b0;
        data1[5:0] = 6'h07;
        req1 = 4'b0011;
        sb1.push_back(exp_t'{2'd0, 6'h07});
        tick();
        check("t5_next_gid", 32'(gid1), 32'd0);
        tick();
        check("t5_next_ack", 32'(ack1), 32'b0001);
        req1 = 4'b0000;
        tick();
        tick();

        // req dropped during LOAD: load and ack still happen, then nothing more.
        req1 = 4'b0100;
        sb1.push_back(exp_t'{2'd2, 6'h2A});
        tick();
        check("t6_ld", 32'(ld1), 32'd1);
        req1 = 4'b0000;
        tick();
        check("t6_ack", 32'(ack1), 32'b0100);
        check("t6_q", 32'(q1), 32'h2A);
        tick();
        tick();
        check("t6_idle", 32'(busy1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_ld", 32'(ld1), 32'd0);
        end

        check("sb1_left", 32'(sb1.size()), 32'd0);
        check("sb0_left", 32'(sb0.size()), 32'd0);
        check("sb3_left", 32'(sb3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/j_fdsync6_ldarb.md
# j_fdsync6_ldarb

Round-robin load arbiter and sequencer for a shared 6-bit load-enable holding register (the `j_fdsync6` cell) in Jerry. Up to NREQ requesters each present a 6-bit value and a request. The block grants one requester at a time and drives the register's `ld`/`d` pins for exactly one cycle. It then acknowledges the winner and enforces a configurable hold-off before the next grant. The register stays outside this block; its `clk` must be the same `sys_clk` used here.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- HOLD, 1, idle cycles inserted after each ack before the next arbitration; legal range 0..15.
- GW, derived = ceil(log2(NREQ)), width of the grant index.
- sys_clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of `sys_clk`.
- req  in  NREQ  per-requester request level.
- data  in  6*NREQ  per-requester load values; requester i occupies bits [6i+5:6i].
- ack  out  NREQ  one-cycle pulse to the served requester.
- ld  out  1  load enable to the shared register (its `ld` pin).
- d  out  6  load value to the shared register (its `d` pin).
- gid  out  GW  index of the current or most recent winner.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: while any `req` bit is high, select a winner, store it in `gid`, and go to LOAD. With no request, stay in IDLE.
  - LOAD: `ld`=1 for this single cycle. Then go to ACK.
  - ACK: `ack[gid]`=1 for this single cycle. Then go to HOLD if HOLD>0, otherwise to IDLE.
  - HOLD: a down-counter loaded with HOLD−1 on entry. Go to IDLE when it reaches 0.
- Arbitration is round-robin. The search starts at index `ptr`+1 mod NREQ and takes the first asserted `req` in ascending order with wrap. `ptr` updates to the winner on the IDLE→LOAD transition.
- Reset sets `ptr`=NREQ−1, so requester 0 has first priority after reset.
- `d` = `data` slice selected by `gid`. It is driven combinationally in every state; only the LOAD cycle matters.
- `ld` = (state==LOAD) & ~`reset`. The register is never loaded in a reset cycle.
- Requester protocol:
  - Hold `req` and `data` stable from assertion until `ack` is seen.
  - Deassert `req` in the cycle after `ack`.
  - A `req` still high when the block re-enters IDLE counts as a new request.
- Protocol violation: if `req[gid]` drops during LOAD, the load still completes and `ack` is still issued. The block neither checks nor aborts.
- Requests arriving while busy are held pending by the requester; the block keeps no per-requester pending state.

## Timing
- Reset values: state=IDLE, `ptr`=NREQ−1, `gid`=0, HOLD counter=0, `ack`=0, `ld`=0, `busy`=0. `d` follows `data[5:0]`.
- Latency:
  - Request seen in IDLE at cycle n: `ld`=1 in cycle n+1, register `q` holds the new value from cycle n+2, and `ack` pulses in cycle n+2.
  - `ack` therefore coincides with the first cycle in which the register output is valid.
- Grant period:
  - With continuous requests, one grant every 3+HOLD cycles.
  - With HOLD=0, IDLE→LOAD→ACK→IDLE repeats, for one load every 3 cycles.
- `busy` rises in the cycle after the request is seen (LOAD) and falls on re-entry to IDLE.
- Simultaneous requests: exactly one winner per IDLE cycle. Losers are served in round-robin order on later IDLE cycles.
- Wrap-around: with `ptr`=NREQ−1 the search starts at index 0. With `ptr`=k, index k has the lowest priority.
- Single requester: it wins every arbitration regardless of `ptr`.
- Reset mid-operation:
  - Reset asserted in LOAD: `ld` is forced to 0 that cycle, no `ack` is issued, and the state returns to IDLE.
  - Reset asserted in ACK: the `ack` output is still 1 that cycle (it is decoded from state), and the state returns to IDLE.
  - Reset asserted in HOLD: the remaining hold cycles are discarded.
- No combinational path from `req` to `ld` or `ack`. `ld`, `ack` and `busy` are decoded from registered state only (plus reset gating on `ld`).

## Test plan
- Reset then a single request: NREQ=4, HOLD=1, `req`=0100, data slice 2=6'h2A. Required: `ld`=1 one cycle later with `d`=6'h2A and `gid`=2; `q`=6'h2A and `ack`=0100 the cycle after that; `busy` high for 3 cycles.
- All four requesting continuously, HOLD=0, after reset. Required: grant order 0,1,2,3,0; `ack` pulses 3 cycles apart; each `ld` cycle carries the matching data slice.
- Fairness under wrap-around: serve 3, then raise `req`=1001 together. Required: 0 is served before 3.
- HOLD=3 with back-to-back requests. Required: exactly 3 cycles with `busy`=1 and `ld`=0 between an `ack` and the next `ld`; 6-cycle grant period.
- Reset during LOAD with `d`=6'h15 and the register previously 6'h00. Required: `ld`=0 that cycle, register stays 6'h00, no `ack`, `busy`=0 next cycle, and the next grant goes to requester 0.
- `req` deasserted during LOAD (protocol violation). Required: the load still happens and `ack` still pulses; then the block returns to IDLE and issues no further `ld` for that requester.
